// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage.
// Widths, opcode field position, fetch FSM states.
package fetch_stage_pkg;

    localparam int PC_WIDTH = 16;
    localparam int INSTR_WIDTH = 16;
    localparam int OPCODE_WIDTH = 4;
    localparam int OPCODE_MSB = INSTR_WIDTH - 1;

    localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic logic is_opcode(
        input logic [INSTR_WIDTH-1:0] word,
        input logic [OPCODE_WIDTH-1:0] opcode
    );
        return word[OPCODE_MSB -: OPCODE_WIDTH] == opcode;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control from execute/hazard logic,
// instruction memory port and IF/ID outputs to decode.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                   i_stall;
    logic                   i_branch_taken;
    logic [PC_WIDTH-1:0]    i_branch_target;
    logic [PC_WIDTH-1:0]    o_imem_addr;
    logic [INSTR_WIDTH-1:0] i_imem_data;
    logic                   o_decode_valid;
    logic [INSTR_WIDTH-1:0] o_decode_instr;
    logic [PC_WIDTH-1:0]    o_decode_pc;
    logic                   o_halted;
    logic [15:0]            o_stall_count;

    modport master (
        output i_stall,
        output i_branch_taken,
        output i_branch_target,
        output i_imem_data,
        input  o_imem_addr,
        input  o_decode_valid,
        input  o_decode_instr,
        input  o_decode_pc,
        input  o_halted,
        input  o_stall_count
    );

    modport slave (
        input  i_stall,
        input  i_branch_taken,
        input  i_branch_target,
        input  i_imem_data,
        output o_imem_addr,
        output o_decode_valid,
        output o_decode_instr,
        output o_decode_pc,
        output o_halted,
        output o_stall_count
    );

endinterface

// File: rtl/fetch_decode_register.sv
// Generic pipeline register: load, hold, flush.
// Flush only drops valid; payload keeps its last value.
module fetch_decode_register #(
    parameter int INSTR_W = 16,
    parameter int PC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] next_instr,
    input  logic [PC_W-1:0]    next_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= next_instr;
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, fetch FSM, stall counter
// and the IF/ID register feeding decode.
module fetch_stage #(
    parameter logic [fetch_stage_pkg::PC_WIDTH-1:0] RESET_PC =
        fetch_stage_pkg::RESET_PC,
    parameter logic [fetch_stage_pkg::OPCODE_WIDTH-1:0] HALT_OPCODE =
        fetch_stage_pkg::HALT_OPCODE
) (
    input logic i_clk,
    input logic i_reset_n,
    fetch_stage_if.slave bus
);
    import fetch_stage_pkg::*;

    fetch_state_t state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0] stall_count;
    logic halted;

    logic running;
    logic halt_hit;
    logic load;
    logic flush;

    assign running = state == RUN;
    assign halt_hit = is_opcode(bus.i_imem_data, HALT_OPCODE);

    // Branch beats stall; HALTED keeps flushing so valid drops.
    always_comb begin
        load = running && !bus.i_branch_taken && !bus.i_stall;
        flush = (running && bus.i_branch_taken) || state == HALTED;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= START;
            pc <= RESET_PC;
            stall_count <= '0;
            halted <= 1'b0;
        end else begin
            unique case (state)
                START: state <= RUN;
                RUN: begin
                    if (bus.i_branch_taken) begin
                        pc <= bus.i_branch_target;
                    end else if (!bus.i_stall) begin
                        if (halt_hit) begin
                            state <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                    if (bus.i_stall && stall_count != 16'hFFFF) begin
                        stall_count <= stall_count + 16'd1;
                    end
                end
                HALTED: halted <= 1'b1;
                default: state <= START;
            endcase
        end
    end

    assign bus.o_imem_addr = pc;
    assign bus.o_halted = halted;
    assign bus.o_stall_count = stall_count;

    fetch_decode_register #(
        .INSTR_W(INSTR_WIDTH),
        .PC_W(PC_WIDTH)
    ) u_if_id (
        .clk(i_clk),
        .rst_n(i_reset_n),
        .load(load),
        .flush(flush),
        .next_instr(bus.i_imem_data),
        .next_pc(pc),
        .valid(bus.o_decode_valid),
        .instr(bus.o_decode_instr),
        .pc(bus.o_decode_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table,
// wrap/reset/saturation sequences and a random model run.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int checks;
    int errors;

    logic [15:0] mem [0:65535];

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    assign bus.i_imem_data = mem[bus.o_imem_addr];
    assign bus2.i_imem_data = mem[bus2.o_imem_addr];

    fetch_stage dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus.slave)
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
        .i_clk(clk),
        .i_reset_n(rst2_n),
        .bus(bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        v;
        logic [15:0] dpc;
        logic [15:0] din;
        logic [15:0] addr;
        int          halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    int m_state;
    logic [15:0] m_pc;
    logic m_v;
    logic [15:0] m_dpc;
    logic [15:0] m_din;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic br,
                        input logic [15:0] tgt);
        bus.i_stall = st;
        bus.i_branch_taken = br;
        bus.i_branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic br,
                                input logic [15:0] tgt, input logic v,
                                input logic [15:0] dpc,
                                input logic [15:0] din,
                                input logic [15:0] addr, input int h,
                                input logic [15:0] cnt);
        vec_t r;
        r.stall = st; r.br = br; r.tgt = tgt; r.v = v;
        r.dpc = dpc; r.din = din; r.addr = addr;
        r.halted = h; r.cnt = cnt;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc = 16'h0000;
        m_v = 1'b0;
        m_dpc = '0;
        m_din = '0;
        m_cnt = '0;
    endtask

    task automatic model_edge(input logic st, input logic br,
                              input logic [15:0] tgt);
        logic [15:0] word;
        word = mem[m_pc];
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (st && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (br) begin
                m_pc = tgt;
                m_v = 1'b0;
            end else if (!st) begin
                m_v = 1'b1;
                m_dpc = m_pc;
                m_din = word;
                if (word[15:12] == 4'hF) m_state = 2;
                else m_pc = m_pc + 16'd1;
            end
        end else begin
            m_v = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_decode_valid), 32'd0);
        chk({tag, "_instr"}, 32'(bus.o_decode_instr), 32'd0);
        chk({tag, "_dpc"}, 32'(bus.o_decode_pc), 32'd0);
        chk({tag, "_addr"}, 32'(bus.o_imem_addr), 32'd0);
        chk({tag, "_halted"}, 32'(bus.o_halted), 32'd0);
        chk({tag, "_cnt"}, 32'(bus.o_stall_count), 32'd0);
    endtask

    initial begin
        logic st;
        logic br;
        logic [15:0] tgt;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_branch_taken = 1'b0;
        bus.i_branch_target = '0;
        bus2.i_stall = 1'b0;
        bus2.i_branch_taken = 1'b0;
        bus2.i_branch_target = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[0] = 16'h1000;
        mem[1] = 16'h1001;
        mem[2] = 16'h1002;
        mem[3] = 16'hF000;
        mem[16'h40] = 16'h2040;
        mem[16'h41] = 16'h2041;
        mem[16'hFFFF] = 16'h3FFF;

        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 16'h1000, 16'h0001, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h1001, 16'h0002, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h1001, 16'h0002, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h1001, 16'h0002, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h1001, 16'h0002, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 2, 16'h1002, 16'h0003, 0, 3));
        tbl.push_back(mk(1, 1, 16'h40, 0, 0, 0, 16'h0040, 0, 4));
        tbl.push_back(mk(0, 0, 0, 1, 16'h40, 16'h2040, 16'h0041, 0, 4));
        tbl.push_back(mk(0, 1, 16'h3, 0, 0, 0, 16'h0003, 0, 4));
        // branch during a HALT fetch: branch wins
        tbl.push_back(mk(0, 1, 16'h40, 0, 0, 0, 16'h0040, 0, 4));
        tbl.push_back(mk(0, 1, 16'h3, 0, 0, 0, 16'h0003, 0, 4));
        tbl.push_back(mk(0, 0, 0, 1, 3, 16'hF000, 16'h0003, -1, 4));
        tbl.push_back(mk(1, 1, 16'h40, 0, 0, 0, 16'h0003, 1, 4));
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(1'($urandom), 1'($urandom),
                             16'($urandom), 0, 0, 0, 16'h0003, 1, 4));
        end

        #1;
        chk_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].stall, tbl[i].br, tbl[i].tgt);
            chk($sformatf("t%0d_valid", i),
                32'(bus.o_decode_valid), 32'(tbl[i].v));
            chk($sformatf("t%0d_addr", i),
                32'(bus.o_imem_addr), 32'(tbl[i].addr));
            chk($sformatf("t%0d_cnt", i),
                32'(bus.o_stall_count), 32'(tbl[i].cnt));
            if (tbl[i].v) begin
                chk($sformatf("t%0d_dpc", i),
                    32'(bus.o_decode_pc), 32'(tbl[i].dpc));
                chk($sformatf("t%0d_instr", i),
                    32'(bus.o_decode_instr), 32'(tbl[i].din));
            end
            if (tbl[i].halted >= 0) begin
                chk($sformatf("t%0d_halted", i),
                    32'(bus.o_halted), 32'(tbl[i].halted));
            end
        end

        // PC wrap from RESET_PC = 16'hFFFF
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_start_valid", 32'(bus2.o_decode_valid), 32'd0);
        chk("wrap_start_addr", 32'(bus2.o_imem_addr), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap_pc0", 32'(bus2.o_decode_pc), 32'hFFFF);
        chk("wrap_instr0", 32'(bus2.o_decode_instr), 32'h3FFF);
        chk("wrap_addr0", 32'(bus2.o_imem_addr), 32'h0000);
        @(posedge clk);
        #1;
        chk("wrap_pc1", 32'(bus2.o_decode_pc), 32'h0000);
        chk("wrap_instr1", 32'(bus2.o_decode_instr), 32'h1000);
        chk("wrap_valid1", 32'(bus2.o_decode_valid), 32'd1);

        // random run against the model, with async resets between edges
        for (int a = 0; a < 256; a++) begin
            mem[a] = {(($urandom % 30) == 0) ? 4'hF : 4'($urandom % 15),
                      12'($urandom)};
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst1");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ((m_state == 2 && ($urandom % 6) == 0) ||
                ($urandom % 400) == 0) begin
                rst_n = 1'b0;
                #2;
                chk_reset_outputs($sformatf("arst%0d", n));
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                st = ($urandom % 10) < 3;
                br = ($urandom % 10) == 0;
                tgt = 16'($urandom_range(0, 255));
                model_edge(st, br, tgt);
                step(st, br, tgt);
                chk($sformatf("r%0d_valid", n),
                    32'(bus.o_decode_valid), 32'(m_v));
                chk($sformatf("r%0d_addr", n),
                    32'(bus.o_imem_addr), 32'(m_pc));
                chk($sformatf("r%0d_halted", n),
                    32'(bus.o_halted), 32'(m_state == 2));
                chk($sformatf("r%0d_cnt", n),
                    32'(bus.o_stall_count), 32'(m_cnt));
                if (m_v) begin
                    chk($sformatf("r%0d_dpc", n),
                        32'(bus.o_decode_pc), 32'(m_dpc));
                    chk($sformatf("r%0d_instr", n),
                        32'(bus.o_decode_instr), 32'(m_din));
                end
            end
        end

        // stall counter saturation
        mem[0] = 16'h1000;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step(0, 0, 0);
        bus.i_stall = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(bus.o_stall_count), 32'hFFFE);
        chk("sat_addr_hold", 32'(bus.o_imem_addr), 32'h0000);
        step(1, 0, 0);
        chk("sat_ffff", 32'(bus.o_stall_count), 32'hFFFF);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("sat_stay", 32'(bus.o_stall_count), 32'hFFFF);
        step(0, 0, 0);
        chk("sat_resume_valid", 32'(bus.o_decode_valid), 32'd1);
        chk("sat_resume_cnt", 32'(bus.o_stall_count), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Generates the program counter, reads instruction memory (asynchronous read, same-cycle data) and presents the fetched instruction to decode.
- Obeys the pipeline stall produced from the decode-stage hazard check. Accepts branch redirects from execute.
- Stops fetching on a HALT opcode. Counts stall cycles for performance debug.

Parameters:
PC_WIDTH, 16, program-counter and instruction-address width (word addressed)
INSTR_WIDTH, 16, instruction word width
HALT_OPCODE, 4'hF, value of instruction bits [INSTR_WIDTH-1 -: 4] that halts fetch
RESET_PC, 0, PC value loaded on reset

Ports:
i_clk  input  1  clock, rising edge
i_reset_n  input  1  asynchronous active-low reset
i_stall  input  1  hazard stall: hold PC and IF/ID contents
i_branch_taken  input  1  execute-stage redirect request
i_branch_target  input  PC_WIDTH  redirect address
o_imem_addr  output  PC_WIDTH  instruction memory address (= PC)
i_imem_data  input  INSTR_WIDTH  instruction at o_imem_addr, same cycle
o_decode_valid  output  1  IF/ID holds a real instruction
o_decode_instr  output  INSTR_WIDTH  IF/ID instruction
o_decode_pc  output  PC_WIDTH  PC of IF/ID instruction
o_halted  output  1  fetch has stopped on HALT
o_stall_count  output  16  saturating count of cycles with i_stall=1 while state=RUN

Behaviour:
- One clock domain; reset asynchronous, active-low.
- On reset assertion, immediately:
  - PC=RESET_PC, state=START
  - o_decode_valid=0, o_decode_instr=0, o_decode_pc=0
  - o_halted=0, o_stall_count=0
- Reset mid-operation discards any in-flight instruction and branch.
- State machine:
  - START: one cycle after reset release, no fetch, IF/ID stays invalid. Next state is RUN.
  - RUN: fetch active.
  - HALTED: o_halted=1, PC frozen, o_decode_valid=0. Left only by reset.
- o_imem_addr = PC at all times (combinational from the PC register).
- RUN, per rising edge, highest priority first:
  1. i_branch_taken=1: PC<=i_branch_target; o_decode_valid<=0 (flush). Takes precedence over i_stall and HALT detection; the bubble occupies IF/ID for one cycle.
  2. i_stall=1: PC, o_decode_valid, o_decode_instr and o_decode_pc all hold. o_stall_count increments, saturating at 16'hFFFF.
  3. Fetched word i_imem_data has opcode == HALT_OPCODE: IF/ID loads it with o_decode_valid<=1 so decode sees HALT; PC holds; state<=HALTED. In HALTED, o_decode_valid goes to 0 on the next edge.
  4. Otherwise: o_decode_instr<=i_imem_data, o_decode_pc<=PC, o_decode_valid<=1, PC<=PC+1.
- Latency: the instruction at address A appears on o_decode_instr the edge after PC=A with no stall. One instruction per cycle with no hazards.
- PC wraps modulo 2^PC_WIDTH: all-ones + 1 = 0, with no flag.
- i_stall and i_branch_taken are ignored in START and HALTED. o_stall_count does not change in those states.
- A branch in the same cycle as a HALT fetch: the branch wins and HALT is not detected.

Decomposition:
- Shared pipeline package holds:
  - PC_WIDTH, INSTR_WIDTH, HALT_OPCODE and the opcode field position
  - fetch state enum {START, RUN, HALTED}, 2 bits
  - RESET_PC
- Natural sub-module: fetch_decode_register. It is the IF/ID register with load, hold and flush controls, and is reused for later pipeline registers.
- The PC, state machine and stall counter stay in fetch_stage.

Test Plan:
- Memory holds 0x1000,0x1001,0x1002 at 0..2; release reset → START for 1 cycle, then o_decode_pc=0,1,2 on consecutive cycles with o_decode_instr=0x1000,0x1001,0x1002 and valid=1.
- i_stall=1 for 3 cycles while IF/ID holds pc=1 → IF/ID stays pc=1/0x1001, o_imem_addr stays 2, o_stall_count=3; after release the next decode pc is 2.
- i_branch_taken=1 with target 0x0040 while i_stall=1 → next cycle valid=0 and o_imem_addr=0x0040; following cycle o_decode_pc=0x0040.
- Word 0xF000 at address 3 → IF/ID gets pc=3/0xF000 valid=1, then valid=0 and o_halted=1. PC stays 3 for 10 cycles; stall and branch inputs have no effect.
- RESET_PC=16'hFFFF → decode pcs 0xFFFF then 0x0000 (wrap).
- Assert i_reset_n=0 mid-stream asynchronously (between edges) → outputs zero immediately and o_imem_addr=RESET_PC; force o_stall_count to 0xFFFF with more stalls → it saturates and stays at 0xFFFF.
